// File: rtl/err_rate_tuner.sv
// err_rate_tuner: supervisor that tunes the detection delay-line code of a
// timing-error-resilient pipeline stage.
//
// Over a window of WINDOW qualified samples it counts dual-rail error
// outcomes. At the end of each window it steps the delay-line code up (more
// margin) or down (less margin), or leaves it where it is. Each new code is
// delivered through a 4-phase req/ack handshake, followed by a settle
// interval during which samples are ignored.
//
// Optional feature: define ERR_STATS_EN to build the saturating lifetime
// error counter and its err_total port.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   en         tuning enable
//   smp_vld    one-cycle strobe, err1/err0 valid this cycle
//   err1       error rail
//   err0       no-error rail
//   cfg_ack    delay-line acknowledge (4-phase)
//   cfg_req    delay-line request (4-phase)
//   dly_code   current delay-line code
//   busy       high in any state other than COUNT/IDLE
//   illegal    sticky flag: err1&err0 seen on a qualified strobe
//   err_total  saturating lifetime error count (ERR_STATS_EN only)
module err_rate_tuner #(
  parameter int unsigned CODE_W   = 4,
  parameter int unsigned CODE_MIN = 0,
  parameter int unsigned CODE_MAX = 15,
  parameter int unsigned CODE_RST = 8,
  parameter int unsigned WINDOW   = 128,
  parameter int unsigned HI_TH    = 4,
  parameter int unsigned LO_TH    = 0,
  parameter int unsigned SETTLE   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              smp_vld,
  input  logic              err1,
  input  logic              err0,
  input  logic              cfg_ack,
  output logic              cfg_req,
  output logic [CODE_W-1:0] dly_code,
  output logic              busy,
  output logic              illegal
`ifdef ERR_STATS_EN
  ,
  output logic [15:0]       err_total
`endif
);

  localparam int unsigned CNT_W = $clog2(WINDOW + 1);
  localparam int unsigned SET_W = $clog2(SETTLE + 1);

  localparam logic [CNT_W-1:0]  WIN_LAST = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT  = '1;
  localparam logic [CNT_W-1:0]  HI_C     = CNT_W'(HI_TH);
  localparam logic [CNT_W-1:0]  LO_C     = CNT_W'(LO_TH);
  localparam logic [CODE_W-1:0] MIN_C    = CODE_W'(CODE_MIN);
  localparam logic [CODE_W-1:0] MAX_C    = CODE_W'(CODE_MAX);
  localparam logic [CODE_W-1:0] RST_C    = CODE_W'(CODE_RST);
  localparam logic [SET_W-1:0]  SET_C    = SET_W'(SETTLE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_EVAL,
    S_REQ,
    S_RELEASE,
    S_SETTLE
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  smp_cnt, smp_cnt_nxt;
  logic [CNT_W-1:0]  err_cnt, err_cnt_nxt;
  logic [SET_W-1:0]  set_cnt, set_cnt_nxt;
  logic [CODE_W-1:0] code_nxt;
  logic              req_nxt;
  logic              busy_nxt;
  logic              illegal_nxt;

  // A sample counts only while counting with tuning enabled and at least one
  // rail asserted; an all-zero strobe carries no outcome.
  logic qual, is_err;
  assign qual   = (state == S_COUNT) && en && smp_vld && (err1 || err0);
  assign is_err = qual && err1;

  // Next-state and next-output logic.
  always_comb begin
    state_nxt   = state;
    smp_cnt_nxt = smp_cnt;
    err_cnt_nxt = err_cnt;
    set_cnt_nxt = set_cnt;
    code_nxt    = dly_code;
    req_nxt     = cfg_req;
    illegal_nxt = illegal || (qual && err1 && err0);

    case (state)
      S_IDLE: begin
        if (en) begin
          state_nxt   = S_COUNT;
          smp_cnt_nxt = '0;
          err_cnt_nxt = '0;
        end
      end

      S_COUNT: begin
        if (!en) begin
          state_nxt   = S_IDLE;
          smp_cnt_nxt = '0;
          err_cnt_nxt = '0;
        end else if (qual) begin
          smp_cnt_nxt = smp_cnt + CNT_W'(1);
          if (is_err && (err_cnt != CNT_SAT)) begin
            err_cnt_nxt = err_cnt + CNT_W'(1);
          end
          if (smp_cnt == WIN_LAST) begin
            state_nxt = S_EVAL;
          end
        end
      end

      // One-cycle decision; the new code and the request leave on the same edge.
      S_EVAL: begin
        if ((err_cnt >= HI_C) && (dly_code < MAX_C)) begin
          code_nxt  = dly_code + CODE_W'(1);
          req_nxt   = 1'b1;
          state_nxt = S_REQ;
        end else if ((err_cnt <= LO_C) && (dly_code > MIN_C)) begin
          code_nxt  = dly_code - CODE_W'(1);
          req_nxt   = 1'b1;
          state_nxt = S_REQ;
        end else begin
          state_nxt   = en ? S_COUNT : S_IDLE;
          smp_cnt_nxt = '0;
          err_cnt_nxt = '0;
        end
      end

      // cfg_req is already high for this whole cycle, so an ack that was
      // high on entry still sees at least one cycle of request.
      S_REQ: begin
        if (cfg_ack) begin
          req_nxt   = 1'b0;
          state_nxt = S_RELEASE;
        end
      end

      S_RELEASE: begin
        if (!cfg_ack) begin
          state_nxt   = S_SETTLE;
          set_cnt_nxt = SET_C;
        end
      end

      // Occupies exactly SETTLE cycles before counting resumes.
      S_SETTLE: begin
        if (set_cnt <= SET_W'(1)) begin
          set_cnt_nxt = '0;
          state_nxt   = en ? S_COUNT : S_IDLE;
          smp_cnt_nxt = '0;
          err_cnt_nxt = '0;
        end else begin
          set_cnt_nxt = set_cnt - SET_W'(1);
        end
      end

      default: begin
        state_nxt   = S_IDLE;
        req_nxt     = 1'b0;
        smp_cnt_nxt = '0;
        err_cnt_nxt = '0;
      end
    endcase

    busy_nxt = (state_nxt != S_IDLE) && (state_nxt != S_COUNT);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      smp_cnt  <= '0;
      err_cnt  <= '0;
      set_cnt  <= '0;
      dly_code <= RST_C;
      cfg_req  <= 1'b0;
      busy     <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      state    <= state_nxt;
      smp_cnt  <= smp_cnt_nxt;
      err_cnt  <= err_cnt_nxt;
      set_cnt  <= set_cnt_nxt;
      dly_code <= code_nxt;
      cfg_req  <= req_nxt;
      busy     <= busy_nxt;
      illegal  <= illegal_nxt;
    end
  end

`ifdef ERR_STATS_EN
  // Lifetime error count; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_total <= '0;
    end else if (is_err && (err_total != 16'hFFFF)) begin
      err_total <= err_total + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_err_rate_tuner.sv
// Scoreboard bench for err_rate_tuner: stimulus queues the code expected on
// each request; a monitor pops and compares whenever cfg_req rises.
module tb_err_rate_tuner;

  localparam int WINDOW = 128;
  localparam int SETTLE = 8;

  logic       clk;
  logic       rst;
  logic       en;
  logic       smp_vld;
  logic       err1;
  logic       err0;
  logic       cfg_ack;
  logic       cfg_req;
  logic [3:0] dly_code;
  logic       busy;
  logic       illegal;
`ifdef ERR_STATS_EN
  logic [15:0] err_total;
`endif

  err_rate_tuner dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .smp_vld  (smp_vld),
    .err1     (err1),
    .err0     (err0),
    .cfg_ack  (cfg_ack),
    .cfg_req  (cfg_req),
    .dly_code (dly_code),
    .busy     (busy),
    .illegal  (illegal)
`ifdef ERR_STATS_EN
    ,
    .err_total(err_total)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  bit ack_on  = 1'b1;
  int ack_dly = 3;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Delay-line model: raise ack ack_dly cycles after req, drop it once req falls.
  initial begin
    cfg_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_on && rst && cfg_req && !cfg_ack) begin
        repeat (ack_dly) @(negedge clk);
        cfg_ack = 1'b1;
        for (int n = 0; n < 1000 && cfg_req; n++) @(negedge clk);
        cfg_ack = 1'b0;
      end
    end
  end

  // Monitor: each request must carry the next queued code, held stable
  // until the handshake finishes.
  initial begin
    logic       req_d;
    logic [3:0] held;
    req_d = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        req_d = 1'b0;
      end else begin
        if (cfg_req && !req_d) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_req: code %0d requested, none expected (t=%0t)",
                     dly_code, $time);
          end else begin
            chk("req_code", int'(dly_code), exp_q.pop_front());
          end
          held = dly_code;
        end else if (cfg_req || cfg_ack) begin
          chk("code_stable", int'(dly_code), int'(held));
        end
        req_d = cfg_req;
      end
    end
  end

  // Zero-rail strobes first, then n_tot strobes: illegal, error, then clean.
  task automatic send_strobes(input int n_zero, input int n_ill, input int n_err,
                              input int n_tot);
    for (int i = 0; i < n_zero; i++) begin
      @(negedge clk);
      smp_vld = 1'b1; err1 = 1'b0; err0 = 1'b0;
    end
    for (int i = 0; i < n_tot; i++) begin
      @(negedge clk);
      smp_vld = 1'b1;
      err1    = (i < n_ill + n_err);
      err0    = (i < n_ill) || (i >= n_ill + n_err);
    end
  endtask

  // One full window plus its evaluation; strobes are injected throughout
  // the settle interval and must be dropped.
  task automatic run_window(input int n_zero, input int n_ill, input int n_err,
                            input bit chg, input int exp_code);
    int  sc;
    int  n;
    bit  fell;
    if (chg) exp_q.push_back(exp_code);
    send_strobes(n_zero, n_ill, n_err, WINDOW);
    @(negedge clk);
    smp_vld = 1'b0; err1 = 1'b0; err0 = 1'b0;
    chk("eval_req", int'(cfg_req), 0);
    chk("eval_busy", int'(busy), 1);
    @(negedge clk);
    chk("latency_req", int'(cfg_req), int'(chg));
    if (chg) begin
      sc   = 0;
      n    = 0;
      fell = 1'b0;
      while (busy && n < 3000) begin
        @(negedge clk);
        n++;
        if (fell && busy) sc++;
        if (!cfg_req) begin
          fell    = 1'b1;
          smp_vld = 1'b1; err1 = 1'b1; err0 = 1'b0;
        end
      end
      smp_vld = 1'b0; err1 = 1'b0;
      if (n >= 3000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL handshake_timeout: busy still 1 after %0d cycles, expected 0", n);
      end
      chk("settle_cycles", sc, SETTLE);
    end else begin
      chk("hold_busy", int'(busy), 0);
    end
    chk("window_code", int'(dly_code), exp_code);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; smp_vld = 1'b0; err1 = 1'b0; err0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_code", int'(dly_code), 8);
    chk("rst_req", int'(cfg_req), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_illegal", int'(illegal), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    en = 1'b1;
    @(negedge clk);

    // Five errors in a window: step up with the full handshake.
    ack_dly = 3;
    run_window(0, 0, 5, 1'b1, 9);

    // Clean windows walk the code down to the floor, then clamp there.
    for (int c = 8; c >= 0; c--) begin
      ack_dly = c % 4;
      run_window(0, 0, 0, 1'b1, c);
    end
    run_window(0, 0, 0, 1'b0, 0);

    // Exactly HI_TH errors steps up; 1..3 errors hold the code.
    ack_dly = 1;
    run_window(0, 0, 4, 1'b1, 1);
    run_window(0, 0, 2, 1'b0, 1);
    run_window(0, 0, 3, 1'b0, 1);
    run_window(0, 0, 1, 1'b0, 1);

    // Illegal strobe counts as an error; all-zero strobes are not samples.
    chk("illegal_before", int'(illegal), 0);
    run_window(5, 1, 3, 1'b1, 2);
    chk("illegal_sticky", int'(illegal), 1);

    // Dropping en mid-window discards the partial count.
    send_strobes(0, 0, 60, 60);
    @(negedge clk);
    smp_vld = 1'b0; err1 = 1'b0; err0 = 1'b0;
    en = 1'b0;
    @(negedge clk);
    chk("en_off_busy", int'(busy), 0);
    en = 1'b1;
    run_window(0, 0, 0, 1'b1, 1);

    // Asynchronous reset in the middle of a request.
    ack_on = 1'b0;
    exp_q.push_back(2);
    send_strobes(0, 0, 4, WINDOW);
    @(negedge clk);
    smp_vld = 1'b0; err1 = 1'b0; err0 = 1'b0;
    @(negedge clk);
    chk("req_pending", int'(cfg_req), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_req", int'(cfg_req), 0);
    chk("async_code", int'(dly_code), 8);
    chk("async_illegal", int'(illegal), 0);
    chk("async_busy", int'(busy), 0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    ack_on = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_req", int'(cfg_req), 0);

`ifdef ERR_STATS_EN
    // Lifetime counter saturates and survives en toggling.
    chk("stats_reset", int'(err_total), 0);
    ack_dly = 0;
    for (int c = 9; c <= 15; c++) exp_q.push_back(c);
    en = 1'b1;
    @(negedge clk);
    send_strobes(0, 0, 67000, 67000);
    @(negedge clk);
    smp_vld = 1'b0; err1 = 1'b0;
    for (int n = 0; n < 100 && busy; n++) @(negedge clk);
    chk("stats_code_clamp", int'(dly_code), 15);
    chk("stats_sat", int'(err_total), 65535);
    en = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    repeat (2) @(negedge clk);
    chk("stats_keep", int'(err_total), 65535);
`endif

    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
